// File: rtl/bus2_line_initiator.sv
// Cache-side master of bus2: issues one line read or write on A2/D2/C2,
// streams or captures the line beats, and returns a one-cycle completion.
module bus2_line_initiator #(
    parameter int ADDR2_BUS_SIZE  = 15,
    parameter int DATA2_BUS_SIZE  = 16,
    parameter int CTR2_BUS_SIZE   = 2,
    parameter int CACHE_LINE_SIZE = 16,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                         CLK,
    input  logic                         RESET,
    inout  wire  [ADDR2_BUS_SIZE-1:0]    A2_WIRE,
    inout  wire  [DATA2_BUS_SIZE-1:0]    D2_WIRE,
    inout  wire  [CTR2_BUS_SIZE-1:0]     C2_WIRE,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR2_BUS_SIZE-1:0]    req_addr,
    input  logic [CACHE_LINE_SIZE*8-1:0] req_wdata,
    output logic                         resp_valid,
    output logic                         resp_err,
    output logic [CACHE_LINE_SIZE*8-1:0] resp_rdata,
    output logic                         busy
);

    localparam int DATA2_BUS_SIZE_BYTES = DATA2_BUS_SIZE / 8;
    localparam int BEATS  = CACHE_LINE_SIZE / DATA2_BUS_SIZE_BYTES;
    localparam int LINE_W = CACHE_LINE_SIZE * 8;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WDATA, S_WAIT, S_RDATA, S_DONE
    } state_t;

    state_t                      state_q;
    logic [BW-1:0]               beat_q;
    logic [TW-1:0]               tmo_q;
    logic                        err_q;
    logic                        req_ready_q;
    logic                        busy_q;
    logic                        resp_valid_q;
    logic [LINE_W-1:0]           rdata_q;
    logic                        write_q;
    logic [ADDR2_BUS_SIZE-1:0]   addr_q;
    logic [LINE_W-1:0]           wdata_q;

    logic                        c2_resp;
    logic                        beat_last;
    logic                        tmo_hit;
    logic [DATA2_BUS_SIZE-1:0]   wbeat;

    assign c2_resp   = (C2_WIRE == C2_RESPONSE);
    assign beat_last = (beat_q == BW'(BEATS - 1));
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) &&
                       (({{(32-TW){1'b0}}, tmo_q} + 32'd1) == TIMEOUT_CYCLES);
    assign wbeat     = wdata_q[int'(beat_q)*DATA2_BUS_SIZE +: DATA2_BUS_SIZE];

    // The initiator owns C2/A2 only during CMD, so the responder can drive C2 in every other cycle.
    assign A2_WIRE = (state_q == S_CMD) ? addr_q : {ADDR2_BUS_SIZE{1'bz}};
    assign C2_WIRE = (state_q == S_CMD) ? (write_q ? C2_WRITE_LINE : C2_READ_LINE)
                                        : {CTR2_BUS_SIZE{1'bz}};
    assign D2_WIRE = (write_q && (state_q == S_CMD || state_q == S_WDATA))
                     ? wbeat : {DATA2_BUS_SIZE{1'bz}};

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_valid_q & err_q;
    assign resp_rdata = rdata_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        write_q     <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        beat_q      <= '0;
                        err_q       <= 1'b0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_CMD;
                    end
                end
                S_CMD: begin
                    tmo_q <= '0;
                    if (write_q && BEATS > 1) begin
                        beat_q  <= BW'(1);
                        state_q <= S_WDATA;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WDATA: begin
                    // A response arriving before the line is fully sent is a protocol error.
                    if (c2_resp) err_q <= 1'b1;
                    if (beat_last) state_q <= S_WAIT;
                    else           beat_q  <= beat_q + BW'(1);
                end
                S_WAIT: begin
                    if (c2_resp) begin
                        if (write_q) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            rdata_q[DATA2_BUS_SIZE-1:0] <= D2_WIRE;
                            if (BEATS == 1) begin
                                resp_valid_q <= 1'b1;
                                state_q      <= S_DONE;
                            end else begin
                                beat_q  <= BW'(1);
                                state_q <= S_RDATA;
                            end
                        end
                    end else if (tmo_hit) begin
                        err_q        <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_RDATA: begin
                    rdata_q[int'(beat_q)*DATA2_BUS_SIZE +: DATA2_BUS_SIZE] <= D2_WIRE;
                    if (!c2_resp) err_q <= 1'b1;
                    if (beat_last) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        beat_q <= beat_q + BW'(1);
                    end
                end
                S_DONE: begin
                    resp_valid_q <= 1'b0;
                    err_q        <= 1'b0;
                    req_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus2_line_initiator.sv
// Directed bench for bus2_line_initiator: table of line transactions plus
// hand-written reset-abort and back-to-back request sequences.
module tb_bus2_line_initiator;

    localparam int BEATS = 8;
    localparam logic [1:0] C2_NOP  = 2'd0;
    localparam logic [1:0] C2_RESP = 2'd1;
    localparam logic [1:0] C2_RD   = 2'd2;
    localparam logic [1:0] C2_WR   = 2'd3;
    localparam logic [127:0] LINE_A = 128'h100F0E0D0C0B0A090807060504030201;

    logic          CLK = 1'b0;
    logic          RESET;
    wire  [14:0]   A2_WIRE;
    wire  [15:0]   D2_WIRE;
    wire  [1:0]    C2_WIRE;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [14:0]   req_addr;
    logic [127:0]  req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [127:0]  resp_rdata;
    logic          busy;

    logic          m_c2_en, m_d2_en;
    logic [1:0]    m_c2;
    logic [15:0]   m_d2;

    assign C2_WIRE = m_c2_en ? m_c2 : 2'bzz;
    assign D2_WIRE = m_d2_en ? m_d2 : 16'hzzzz;

    bus2_line_initiator #(.TIMEOUT_CYCLES(10)) dut (
        .CLK(CLK), .RESET(RESET),
        .A2_WIRE(A2_WIRE), .D2_WIRE(D2_WIRE), .C2_WIRE(C2_WIRE),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic         wr;
        logic [14:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  base;
        int           delay;
        int           drop;
        bit           no_resp;
        logic         exp_err;
        logic [127:0] exp_rd;
        int           exp_lat;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic release_bus();
        m_c2_en = 1'b0;
        m_d2_en = 1'b0;
    endtask

    task automatic respond_read(input logic [15:0] base, input int drop);
        for (int k = 0; k < BEATS; k++) begin
            m_c2_en = 1'b1;
            m_c2    = (k == drop) ? C2_NOP : C2_RESP;
            m_d2_en = 1'b1;
            m_d2    = base + 16'(k);
            chk("rd_ready_low", 128'(req_ready), 128'(0));
            @(negedge CLK);
        end
        release_bus();
    endtask

    task automatic wait_resp(output logic err, output logic [127:0] rd, output int at);
        at  = -1;
        err = 1'b0;
        rd  = '0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) begin
                err = resp_err;
                rd  = resp_rdata;
                at  = cyc;
                break;
            end
            @(negedge CLK);
        end
        if (at < 0) begin
            chk("resp_bound", 128'(0), 128'(1));
        end else begin
            @(negedge CLK);
            chk("resp_one_cycle", 128'(resp_valid), 128'(0));
            chk("ready_after", 128'({req_ready, busy}), 128'(2'b10));
        end
    endtask

    task automatic txn(input vec_t v, output logic err, output logic [127:0] rd, output int lat);
        int c0, at;
        c0 = cyc;
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge CLK);
        req_valid = 1'b0;
        chk("cmd_a2", 128'(A2_WIRE), 128'(v.addr));
        chk("cmd_c2", 128'(C2_WIRE), 128'(v.wr ? C2_WR : C2_RD));
        chk("cmd_busy_ready", 128'({busy, req_ready}), 128'(2'b10));
        if (v.wr) begin
            for (int k = 0; k < BEATS; k++) begin
                chk("wr_beat", 128'(D2_WIRE), 128'(v.wdata[16*k +: 16]));
                @(negedge CLK);
            end
        end else begin
            @(negedge CLK);
        end
        for (int i = 0; i < v.delay; i++) begin
            m_c2_en = 1'b1;
            m_c2    = C2_NOP;
            @(negedge CLK);
        end
        if (!v.no_resp) begin
            if (v.wr) begin
                m_c2_en = 1'b1;
                m_c2    = C2_RESP;
                @(negedge CLK);
            end else begin
                respond_read(v.base, v.drop);
            end
        end
        release_bus();
        wait_resp(err, rd, at);
        lat = at - c0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic         err;
        logic [127:0] rd;
        int           lat, c0, at, pulses;
        vec_t         pv;

        tbl[0] = '{1'b1, 15'h0123, LINE_A, 16'h0, 5, -1, 1'b0, 1'b0, 128'h0, 15};
        tbl[1] = '{1'b0, 15'h7FFF, 128'h0, 16'hA0B0, 0, -1, 1'b0, 1'b0,
                   128'hA0B7A0B6A0B5A0B4A0B3A0B2A0B1A0B0, 10};
        tbl[2] = '{1'b0, 15'h0001, 128'h0, 16'h1230, 2, 4, 1'b0, 1'b1,
                   128'h12371236123512341233123212311230, 12};
        tbl[3] = '{1'b1, 15'h0555, 128'hFFEEDDCCBBAA99887766554433221100, 16'h0, 0, -1, 1'b0, 1'b0,
                   128'h12371236123512341233123212311230, 10};
        tbl[4] = '{1'b1, 15'h0042, LINE_A, 16'h0, 0, -1, 1'b1, 1'b1,
                   128'h12371236123512341233123212311230, 19};
        tbl[5] = '{1'b0, 15'h2AAA, 128'h0, 16'h5500, 8, -1, 1'b0, 1'b0,
                   128'h55075506550555045503550255015500, 18};

        RESET = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        m_c2 = C2_NOP; m_d2 = '0;
        release_bus();
        repeat (3) @(negedge CLK);
        chk("rst_ready_busy", 128'({req_ready, busy}), 128'(2'b10));
        chk("rst_resp", 128'({resp_valid, resp_err}), 128'(0));
        chk("rst_rdata", resp_rdata, 128'h0);
        RESET = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 6; i++) begin
            txn(tbl[i], err, rd, lat);
            chk("tbl_err", 128'(err), 128'(tbl[i].exp_err));
            chk("tbl_rdata", rd, tbl[i].exp_rd);
            chk("tbl_latency", 128'(lat), 128'(tbl[i].exp_lat));
        end

        // Reset in the middle of a write, while beat 3 is on D2.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0300; req_wdata = LINE_A;
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("abort_beat3", 128'(D2_WIRE), 128'(16'h0807));
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("abort_busy_ready", 128'({busy, req_ready}), 128'(2'b01));
        chk("abort_resp_valid", 128'(resp_valid), 128'(0));
        chk("abort_rdata_clr", resp_rdata, 128'h0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (resp_valid) pulses++;
        end
        chk("abort_no_resp", 128'(pulses), 128'(0));
        pv = '{1'b0, 15'h0777, 128'h0, 16'hD000, 0, -1, 1'b0, 1'b0,
               128'hD007D006D005D004D003D002D001D000, 10};
        txn(pv, err, rd, lat);
        chk("post_rst_err", 128'(err), 128'(0));
        chk("post_rst_rdata", rd, pv.exp_rd);
        chk("post_rst_latency", 128'(lat), 128'(pv.exp_lat));

        // req_valid held across two reads: second must wait for the cycle after DONE.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0100;
        @(negedge CLK);
        chk("b2b_cmd1_a2", 128'(A2_WIRE), 128'(15'h0100));
        req_addr = 15'h0200;
        @(negedge CLK);
        respond_read(16'hBB00, -1);
        wait_resp(err, rd, at);
        chk("b2b_rd1", rd, 128'hBB07BB06BB05BB04BB03BB02BB01BB00);
        chk("b2b_idle_gap", 128'(C2_WIRE === C2_RD), 128'(0));
        c0 = cyc;
        @(negedge CLK);
        req_valid = 1'b0;
        chk("b2b_cmd2_c2", 128'(C2_WIRE), 128'(C2_RD));
        chk("b2b_cmd2_a2", 128'(A2_WIRE), 128'(15'h0200));
        @(negedge CLK);
        respond_read(16'hCC00, -1);
        wait_resp(err, rd, at);
        chk("b2b_rd2", rd, 128'hCC07CC06CC05CC04CC03CC02CC01CC00);
        chk("b2b_err2", 128'(err), 128'(0));
        chk("b2b_latency2", 128'(at - c0), 128'(10));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
